// File: rtl/branch_fwd_pkg.sv
// Shared encodings for the ID-stage branch forwarding / hazard unit.
package branch_fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_fwd_hazard_unit_fwd_src_check.sv
// Per-operand producer match: stall need and forwarding select for one branch source.
// MEM/WB forwarding is enabled by defining BRANCH_FWD_MEMWB_EN.
module fwd_src_check
  import branch_fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              branch,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic              mem_ld,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        need,
  output logic [1:0]        sel
);

  logic live, ex_hit, mem_hit, wb_hit;

  always_comb begin
    live    = branch && (src != '0);
    ex_hit  = live && ex_we  && (ex_rd  == src);
    mem_hit = live && mem_we && (mem_rd == src);
    wb_hit  = live && wb_we  && (wb_rd  == src);

    need = 2'd0;
    if (ex_hit)
      need = ex_ld ? 2'd2 : 2'd1;
    else if (mem_hit && mem_ld)
      need = 2'd1;

    // Youngest producer wins; a load in MEM has no data yet and is covered by the stall.
    sel = FWD_RF;
    if (mem_hit && !mem_ld)
      sel = FWD_EXMEM;
    else if (wb_hit)
`ifdef BRANCH_FWD_MEMWB_EN
      sel = FWD_MEMWB;
`else
      sel = FWD_RF;
`endif
  end

endmodule

// File: rtl/branch_fwd_hazard_unit.sv
// ID-stage branch operand forwarding and hazard stall unit (IDLE/HOLD FSM, stall counter).
// Optional MEM/WB forwarding path: define BRANCH_FWD_MEMWB_EN.
module branch_fwd_hazard_unit
  import branch_fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      ID_Branch,
  input  logic [NUM_SRC*REG_AW-1:0] src_ID,
  input  logic [REG_AW-1:0]         ID_EX_rd,
  input  logic                      ID_EX_RegWrite,
  input  logic                      ID_EX_MemRead,
  input  logic [REG_AW-1:0]         EX_MEM_rd,
  input  logic                      EX_MEM_RegWrite,
  input  logic                      EX_MEM_MemRead,
  input  logic [REG_AW-1:0]         MEM_WB_rd,
  input  logic                      MEM_WB_RegWrite,
  input  logic                      Flush,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      Stall,
  output logic                      Bubble,
  output logic [CNT_W-1:0]          stall_cycles
);

  logic [1:0]           need [NUM_SRC];
  logic [NUM_SRC*2-1:0] sel_raw;
  logic [1:0]           need_max;
  state_e               state, nxt_state;
  logic [1:0]           cnt, nxt_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_check #(.REG_AW(REG_AW)) u_chk (
      .branch (ID_Branch),
      .src    (src_ID[i*REG_AW +: REG_AW]),
      .ex_rd  (ID_EX_rd),
      .ex_we  (ID_EX_RegWrite),
      .ex_ld  (ID_EX_MemRead),
      .mem_rd (EX_MEM_rd),
      .mem_we (EX_MEM_RegWrite),
      .mem_ld (EX_MEM_MemRead),
      .wb_rd  (MEM_WB_rd),
      .wb_we  (MEM_WB_RegWrite),
      .need   (need[i]),
      .sel    (sel_raw[i*2 +: 2])
    );
  end

  always_comb begin
    need_max = 2'd0;
    for (int i = 0; i < NUM_SRC; i++)
      need_max = max_need(need_max, need[i]);
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    Stall     = 1'b0;
    fwd_sel   = '0;
    if (!Reset) begin
      if (state == ST_IDLE && need_max == 2'd0)
        fwd_sel = sel_raw;
      if (Flush) begin
        nxt_state = ST_IDLE;
        nxt_cnt   = 2'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            Stall = (need_max != 2'd0);
            if (need_max == 2'd2) begin
              nxt_state = ST_HOLD;
              nxt_cnt   = 2'd1;
            end
          end
          ST_HOLD: begin
            Stall   = 1'b1;
            nxt_cnt = cnt - 2'd1;
            if (cnt <= 2'd1)
              nxt_state = ST_IDLE;
          end
          default: nxt_state = ST_IDLE;
        endcase
      end
    end
    Bubble = Stall;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      cnt          <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (Stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
